// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: issues word-aligned fetches, buffers returning words with their PCs
// in a small FIFO, and discards responses that were already in flight when a redirect occurred.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [31:0]   START   = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] in_flight_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   redirect_base;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [1:0]    unused_pc_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A request is only issued when a FIFO slot is already reserved for its response,
  // counting both outstanding requests and words waiting in the queue.
  assign credit_used      = {1'b0, in_flight} + {1'b0, fifo_count};
  assign imem_req_valid_o = !rst_i && !redirect_i && (credit_used < CREDITS);
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign redirect_base  = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits = redirect_pc_i[1:0];

  assign push = imem_rsp_valid_i && !redirect_i && (drop_cnt == '0);
  assign pop  = instr_valid_o && instr_ready_i;

  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr] : '0;
  assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr] : '0;
  assign op_o          = instr_o[6:0];
  assign funct3_o      = instr_o[14:12];
  assign funct7b5_o    = instr_o[30];

  always_comb begin
    in_flight_nxt = in_flight;
    if (req_fire) in_flight_nxt = in_flight_nxt + CW'(1);
    if (imem_rsp_valid_i && in_flight_nxt != '0) in_flight_nxt = in_flight_nxt - CW'(1);
  end

  // On a redirect every request still outstanding after this cycle belongs to the old path,
  // so it becomes the number of responses to throw away.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc   <= START;
      rsp_pc     <= START;
      in_flight  <= '0;
      drop_cnt   <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      in_flight <= in_flight_nxt;
      if (redirect_i) begin
        fetch_pc   <= redirect_base;
        rsp_pc     <= redirect_base;
        drop_cnt   <= in_flight_nxt;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (imem_rsp_valid_i && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop) fifo_count <= fifo_count + CW'(1);
        else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data_i;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && fifo_count == FULL));

endmodule
